regfile_write_port: RTL
=======================

# regfile_write_port

Write side of the processor register file. Holds r1–r31 and drives all 32 register values to the read-port selectors. Two write sources share the single write port:
- the pipeline writeback stage, which is always accepted and has priority;
- a memory-mapped I/O source (crane controller inputs), which uses a valid/ready handshake and is buffered in a 2-entry FIFO until the port is free.

## Interface
Parameters: none (32 registers × 32 bits, FIFO depth 2, fixed).
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- ctrl_writeEnable  in  1  pipeline writeback request, this cycle
- ctrl_writeReg  in  5  pipeline destination register
- data_writeReg  in  32  pipeline write data
- io_valid  in  1  I/O write request
- io_ready  out  1  FIFO can accept; combinational = !ctrl_reset && io_pending != 2
- io_reg  in  5  I/O destination register
- io_data  in  32  I/O write data
- io_pending  out  2  FIFO occupancy, 0..2
- io_commit  out  1  registered pulse: an I/O entry was retired at the last edge
- io_commit_reg  out  5  destination of the retired entry; holds its last value when io_commit = 0
- data_regs  out  1024  register i on bits [32i+31:32i]; bits [31:0] are constant 0

## Operation
- r0 is hardwired to zero. A write to r0 from either source is discarded with no state change.
- Pipeline write:
  - Occurs at the edge when ctrl_writeEnable = 1 and ctrl_writeReg != 0.
  - Always takes effect.
- Port busy: defined as ctrl_writeEnable && ctrl_writeReg != 0.
- I/O push: an entry is accepted at the edge when io_valid && io_ready. The entry is {io_reg, io_data}, written at the tail.
- I/O retire:
  - Occurs at the edge when io_pending > 0 and the port is not busy.
  - The head entry is written to its register and popped.
  - If the head's register is r0, the entry is popped without a write, and io_commit still pulses.
- Port busy and FIFO non-empty: the head waits. There is no starvation guard; the pipeline always wins.
- Same-register conflict in one cycle: not possible, because only one source writes per edge.
- Push and retire at the same edge:
  - Both happen.
  - io_pending is unchanged.
  - The pushed entry goes behind any remaining entry.
- Push into an empty FIFO: the entry cannot retire at the same edge it is pushed. There is no bypass.
- Full FIFO (io_pending = 2): io_ready = 0, so no push is possible that cycle, even if a retire occurs.
- Order: I/O entries retire strictly in FIFO order.
- Occupancy: io_pending is a 2-bit registered counter. +1 on push only, −1 on retire only, unchanged on both or neither. Never wraps.

## Timing
- Reset (at an edge with ctrl_reset = 1):
  - r1–r31 = 0.
  - FIFO is emptied; io_pending = 0.
  - io_commit = 0; io_commit_reg = 0.
  - Reset overrides any write or push in the same cycle.
- During ctrl_reset: io_ready = 0 and pushes are ignored.
- After reset: io_ready = 1 from the first cycle ctrl_reset is low.
- Reset mid-operation: pending I/O entries are lost. No commit pulse is produced for them.
- Pipeline write latency: with a request at edge N, data_regs shows the new value after edge N (visible in cycle N+1).
- I/O latency:
  - Push at edge N, with the port idle at edge N+1: register updated and io_commit = 1 after edge N+1.
  - With an empty FIFO, the minimum push-to-visibility is therefore 2 edges.
- io_commit: high for exactly one cycle per retired entry.
- Throughput: with back-to-back retires, io_commit stays high on consecutive cycles.
- data_regs: driven directly from register flops. No combinational path from any input.

## Test plan
- Reset then idle:
  - data_regs = 0.
  - io_ready = 1, io_pending = 0, io_commit = 0.
  - Pipeline write r5 = 0xDEADBEEF → after 1 edge, data_regs[191:160] = 0xDEADBEEF.
- Write to r0:
  - Pipeline write r0 = 0xFFFFFFFF → data_regs[31:0] stays 0.
  - I/O push r0 = 0x1234 → retires with io_commit = 1, io_commit_reg = 0, and all registers are unchanged.
- Priority and starvation:
  - Hold ctrl_writeEnable = 1 to r7 for 4 cycles.
  - Push I/O r3 = 0xA, then r4 = 0xB → io_pending = 2 and io_ready = 0; a third io_valid is not accepted.
  - Drop ctrl_writeEnable → r3 = 0xA after the next edge and r4 = 0xB after the following edge, with io_commit high on both cycles.
- Simultaneous push and retire:
  - io_pending = 1, port idle, push r9 = 0x55 at the same edge → io_pending stays 1.
  - Head retires; r9 = 0x55 one edge later.
- Write ordering to the same register:
  - Push I/O r2 = 1 then r2 = 2, with the port idle → r2 = 1 after retire 1 and r2 = 2 after retire 2.
  - Then a pipeline write r2 = 3 → r2 = 3.
- Reset mid-operation:
  - With io_pending = 2 and r10 = 0x77, assert ctrl_reset for 1 cycle.
  - Required: r10 = 0, io_pending = 0, no io_commit pulse, io_ready = 0 during reset and 1 after.

Source files
------------

// File: rtl/regfile_write_port.sv
// Write side of the register file: r1-r31 written by the pipeline writeback (priority)
// or by a 2-entry buffered I/O source; all 32 registers are exposed on data_regs.
module regfile_write_port (
   input  logic          clock,
   input  logic          ctrl_reset,
   input  logic          ctrl_writeEnable,
   input  logic [4:0]    ctrl_writeReg,
   input  logic [31:0]   data_writeReg,
   input  logic          io_valid,
   output logic          io_ready,
   input  logic [4:0]    io_reg,
   input  logic [31:0]   io_data,
   output logic [1:0]    io_pending,
   output logic          io_commit,
   output logic [4:0]    io_commit_reg,
   output logic [1023:0] data_regs
);

   logic [31:0] r_regs      [1:31];
   logic [4:0]  r_fifo_reg  [0:1];
   logic [31:0] r_fifo_data [0:1];
   logic        r_head;
   logic        r_tail;
   logic [1:0]  r_pending;
   logic        r_commit;
   logic [4:0]  r_commit_reg;

   logic        w_busy;
   logic        w_push;
   logic        w_retire;
   logic [4:0]  w_head_reg;
   logic [31:0] w_head_data;
   logic        w_wr_en;
   logic [4:0]  w_wr_addr;
   logic [31:0] w_wr_data;

   assign w_busy      = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
   assign io_ready    = !ctrl_reset && (r_pending != 2'd2);
   assign w_push      = io_valid && io_ready;
   assign w_retire    = (r_pending != 2'd0) && !w_busy;
   assign w_head_reg  = r_fifo_reg[r_head];
   assign w_head_data = r_fifo_data[r_head];

   // Single write port: pipeline wins; a retiring r0 entry is dropped here.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = 5'd0;
      w_wr_data = 32'd0;
      if (w_busy) begin
         w_wr_en   = 1'b1;
         w_wr_addr = ctrl_writeReg;
         w_wr_data = data_writeReg;
      end else if (w_retire && (w_head_reg != 5'd0)) begin
         w_wr_en   = 1'b1;
         w_wr_addr = w_head_reg;
         w_wr_data = w_head_data;
      end else begin
         w_wr_en   = 1'b0;
         w_wr_addr = 5'd0;
         w_wr_data = 32'd0;
      end
   end

   // Register array r1-r31.
   always_ff @(posedge clock) begin
      for (int i = 1; i < 32; i++) begin
         if (ctrl_reset) begin
            r_regs[i] <= 32'd0;
         end else if (w_wr_en && (w_wr_addr == 5'(i))) begin
            r_regs[i] <= w_wr_data;
         end
      end
   end

   // I/O FIFO storage and pointers; a push lands behind any entry still held.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         r_head         <= 1'b0;
         r_tail         <= 1'b0;
         r_fifo_reg[0]  <= 5'd0;
         r_fifo_reg[1]  <= 5'd0;
         r_fifo_data[0] <= 32'd0;
         r_fifo_data[1] <= 32'd0;
      end else begin
         if (w_push) begin
            r_fifo_reg[r_tail]  <= io_reg;
            r_fifo_data[r_tail] <= io_data;
            r_tail              <= ~r_tail;
         end
         if (w_retire) begin
            r_head <= ~r_head;
         end
      end
   end

   // Occupancy counter.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         r_pending <= 2'd0;
      end else begin
         case ({w_push, w_retire})
            2'b10:   r_pending <= r_pending + 2'd1;
            2'b01:   r_pending <= r_pending - 2'd1;
            default: r_pending <= r_pending;
         endcase
      end
   end

   // Retire pulse and sticky destination of the last retired entry.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         r_commit     <= 1'b0;
         r_commit_reg <= 5'd0;
      end else begin
         r_commit <= w_retire;
         if (w_retire) begin
            r_commit_reg <= w_head_reg;
         end
      end
   end

   assign io_pending    = r_pending;
   assign io_commit     = r_commit;
   assign io_commit_reg = r_commit_reg;

   assign data_regs[31:0] = 32'd0;
   for (genvar g = 1; g < 32; g++) begin : g_out
      assign data_regs[32*g +: 32] = r_regs[g];
   end

endmodule
